// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encodings, FSM state type and width default for the ALU arbiter
package alu_pkg;

    localparam int WIDTH_DEFAULT = 4;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alu4_core.sv
// rtl/alu4_core.sv - combinational AND/OR/XOR/ADD datapath; carry is the ADD carry-out, 0 otherwise
module alu4_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
            end
        endcase
    end

endmodule

// File: rtl/alu_op_arbiter.sv
// rtl/alu_op_arbiter.sv - round-robin two-requester front end sharing one ALU with a held response channel
// Optional flag outputs rsp_carry/rsp_zero are built when ALU_OP_ARBITER_FLAGS_EN is defined.
module alu_op_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
`ifdef ALU_OP_ARBITER_FLAGS_EN
    output logic             rsp_carry,
    output logic             rsp_zero,
`endif
    output logic [WIDTH-1:0] rsp_data
);

    state_t           state_q, state_d;
    logic             last_id_q, last_id_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    alu4_core #(.WIDTH(WIDTH)) u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // On a tie the requester not served last wins; otherwise the lone valid one.
    assign grant      = (req0_valid && req1_valid) ? ~last_id_q : req1_valid;
    assign accept     = rst_n && (state_q == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;

    always_comb begin
        state_d    = state_q;
        last_id_d  = last_id_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = grant ? req1_op : req0_op;
                    a_d       = grant ? req1_a  : req0_a;
                    b_d       = grant ? req1_b  : req0_b;
                    id_d      = grant;
                    last_id_d = grant;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d = alu_result;
                rsp_id_d   = id_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_id_q  <= 1'b1;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            last_id_q  <= last_id_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

`ifdef ALU_OP_ARBITER_FLAGS_EN
    logic carry_q, carry_d;
    logic zero_q, zero_d;

    always_comb begin
        carry_d = carry_q;
        zero_d  = zero_q;
        if (state_q == ST_EXEC) begin
            carry_d = alu_carry;
            zero_d  = (alu_result == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign rsp_carry = carry_q;
    assign rsp_zero  = zero_q;
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
`endif

endmodule
